// File: rtl/pulse_pacer.sv
// Queues single-cycle event pulses and re-emits them spaced at least MIN_GAP cycles
// apart, so a downstream toggle synchronizer never merges or drops events.
module pulse_pacer #(
    parameter int unsigned MIN_GAP = 16,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_pulse,
    input  logic             i_clr_ovf,
    output logic             o_pulse,
    output logic [CNT_W-1:0] o_pending,
    output logic             o_busy,
    output logic             o_ovf
);

    localparam int unsigned      GAP_W    = $clog2(MIN_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GAP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;
    logic             drop;
    logic             dec;

    // State, gap counter, pending count and registered outputs
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            o_pending <= '0;
            o_ovf     <= 1'b0;
            o_pulse   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            o_pending <= cnt_d;
            o_ovf     <= ovf_d;
            o_pulse   <= (state_d == FIRE);
            o_busy    <= (state_d != IDLE) || (cnt_d != '0);
        end
    end

    // Next-state, gap countdown and saturating pending count
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = o_pending;
        ovf_d   = o_ovf;
        drop    = 1'b0;
        dec     = (state_q == FIRE);

        case (state_q)
            IDLE: begin
                if (i_pulse || (o_pending != '0)) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = (i_pulse || (o_pending != '0)) ? FIRE : IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A simultaneous accept and emit leaves the count unchanged, even at max
        if (i_pulse && !dec) begin
            if (o_pending == CNT_MAX) begin
                drop = 1'b1;
            end else begin
                cnt_d = o_pending + CNT_W'(1);
            end
        end else if (!i_pulse && dec) begin
            cnt_d = o_pending - CNT_W'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: expected o_pulse cycles are queued per scenario and
// matched by a monitor; pending/busy/ovf are spot-checked at hand-computed cycles.
module tb_pulse_pacer;

    localparam int unsigned CNT_W = 4;

    logic             i_clk;
    logic             rst;
    logic             i_pulse;
    logic             i_clr_ovf;
    logic             o_pulse;
    logic [CNT_W-1:0] o_pending;
    logic             o_busy;
    logic             o_ovf;

    pulse_pacer #(.MIN_GAP(16), .CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .rst       (rst),
        .i_pulse   (i_pulse),
        .i_clr_ovf (i_clr_ovf),
        .o_pulse   (o_pulse),
        .o_pending (o_pending),
        .o_busy    (o_busy),
        .o_ovf     (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } obs_t;

    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    int   sb_q[$];
    int   exp_q[$];
    int   pulse_q[$];
    int   clr_q[$];
    int   rst_q[$];
    obs_t obs_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at rel cycle %0d: got %0d expected %0d", name, cyc - base, act, exp);
        end
    endtask

    // Monitor: every o_pulse must match the next expected emission cycle
    always @(negedge i_clk) begin
        if (o_pulse) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at rel cycle %0d: got pulse expected none", cyc - base);
            end else begin
                int e;
                e = sb_q.pop_front();
                if ((cyc - base) != e) begin
                    errors++;
                    $display("FAIL pulse_cycle: got %0d expected %0d", cyc - base, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add_obs(input int c, input int s, input int v);
        obs_t o;
        o.cyc = c;
        o.sig = s;
        o.val = v;
        obs_q.push_back(o);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rst       = 1'b1;
            i_pulse   = 1'b0;
            i_clr_ovf = 1'b0;
        end
        tick();
        rst = 1'b0;
    endtask

    // Runs one scenario of len cycles from the module-level stimulus/expectation queues
    task automatic run(input string scn, input int len);
        foreach (exp_q[i]) sb_q.push_back(exp_q[i]);
        for (int k = 0; k < len; k++) begin
            bit p;
            bit c;
            bit r;
            tick();
            if (k == 0) base = cyc;
            foreach (obs_q[i]) begin
                if (obs_q[i].cyc == k) begin
                    case (obs_q[i].sig)
                        0:       chk({scn, "_pending"}, int'(o_pending), obs_q[i].val);
                        1:       chk({scn, "_busy"}, int'(o_busy), obs_q[i].val);
                        2:       chk({scn, "_ovf"}, int'(o_ovf), obs_q[i].val);
                        default: chk({scn, "_pulse"}, int'(o_pulse), obs_q[i].val);
                    endcase
                end
            end
            p = 1'b0;
            c = 1'b0;
            r = 1'b0;
            foreach (pulse_q[i]) if (pulse_q[i] == k) p = 1'b1;
            foreach (clr_q[i]) if (clr_q[i] == k) c = 1'b1;
            foreach (rst_q[i]) if (rst_q[i] == k) r = 1'b1;
            i_pulse   = p;
            i_clr_ovf = c;
            rst       = r;
        end
        chk({scn, "_missing_pulses"}, sb_q.size(), 0);
        sb_q.delete();
        exp_q.delete();
        pulse_q.delete();
        clr_q.delete();
        rst_q.delete();
        obs_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        i_pulse   = 1'b0;
        i_clr_ovf = 1'b0;
        do_reset(5);

        // Single event
        pulse_q = '{0};
        exp_q   = '{1};
        add_obs(0, 0, 0); add_obs(0, 1, 0); add_obs(0, 2, 0); add_obs(0, 3, 0);
        add_obs(1, 0, 1); add_obs(2, 0, 0);
        add_obs(1, 1, 1); add_obs(16, 1, 1); add_obs(17, 1, 0);
        add_obs(10, 2, 0);
        run("single", 30);

        // Burst of five back-to-back
        for (int i = 0; i < 5; i++) pulse_q.push_back(i);
        exp_q = '{1, 17, 33, 49, 65};
        add_obs(5, 0, 4); add_obs(17, 0, 4); add_obs(18, 0, 3);
        add_obs(70, 0, 0); add_obs(80, 1, 1); add_obs(81, 1, 0);
        run("burst", 90);

        // Overflow: 20 back-to-back, drops at 16, 18, 19
        for (int i = 0; i < 20; i++) pulse_q.push_back(i);
        for (int j = 0; j < 17; j++) exp_q.push_back(1 + 16 * j);
        add_obs(16, 0, 15); add_obs(17, 0, 15); add_obs(18, 0, 15);
        add_obs(20, 0, 15); add_obs(16, 2, 0); add_obs(17, 2, 1);
        add_obs(270, 0, 0); add_obs(275, 1, 0); add_obs(275, 2, 1);
        run("overflow", 280);

        // Overflow clear: plain clear, then clear colliding with a drop
        for (int i = 2; i < 19; i++) pulse_q.push_back(i);
        clr_q = '{0, 18, 19};
        for (int j = 0; j < 16; j++) exp_q.push_back(3 + 16 * j);
        add_obs(0, 2, 1); add_obs(1, 2, 0); add_obs(18, 2, 0);
        add_obs(18, 0, 15); add_obs(19, 2, 1); add_obs(20, 2, 0);
        add_obs(20, 0, 14);
        run("ovf_clear", 260);

        // Sparse input
        pulse_q = '{0, 12, 40};
        exp_q   = '{1, 17, 41};
        add_obs(13, 0, 1); add_obs(33, 1, 0); add_obs(41, 0, 1);
        run("sparse", 70);

        // Reset mid-burst
        for (int i = 0; i < 6; i++) pulse_q.push_back(i);
        pulse_q.push_back(25);
        rst_q = '{20};
        exp_q = '{1, 17, 26};
        add_obs(20, 0, 4);
        add_obs(21, 0, 0); add_obs(21, 1, 0); add_obs(21, 2, 0); add_obs(21, 3, 0);
        add_obs(26, 3, 1); add_obs(27, 0, 0);
        run("reset_mid", 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
